// File: rtl/dram_burst_reader.sv
// Burst read initiator: issues one DRAM read per cycle for a requested burst and
// streams the returned words through a FIFO whose occupancy is protected by credit.
module dram_burst_reader #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 18,
   parameter int LEN_WIDTH  = 10,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  srstn,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [LEN_WIDTH-1:0]  req_len,
   output logic                  dram_en_rd,
   output logic [ADDR_WIDTH-1:0] dram_addr_rd,
   input  logic                  dram_valid,
   input  logic [DATA_WIDTH-1:0] dram_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_last,
   output logic                  busy,
   output logic                  done
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int REM_W = LEN_WIDTH + 1;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [REM_W-1:0]      remaining_q, remaining_d;
   logic [REM_W-1:0]      ret_left_q, ret_left_d;
   logic [CNT_W-1:0]      inflight_q, inflight_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic                  en_rd_q, en_rd_d;
   logic [ADDR_WIDTH-1:0] addr_rd_q, addr_rd_d;
   logic                  done_q, done_d;
   logic [DATA_WIDTH-1:0] data_mem_q [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] data_mem_d [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] last_mem_q, last_mem_d;

   logic                  accept;
   logic                  push;
   logic                  pop;
   logic                  issue;
   logic                  credit_ok;
   logic [CNT_W:0]        reserved_nxt;

   // Datapath: credit check, issue address generation and FIFO bookkeeping
   always_comb begin
      accept       = req_valid && (state_q == IDLE);
      out_valid    = (count_q != '0);
      pop          = out_valid && out_ready;
      push         = dram_valid && (inflight_q != '0);
      reserved_nxt = (CNT_W+1)'(count_q) + (CNT_W+1)'(inflight_q) + (CNT_W+1)'(1)
                     - (CNT_W+1)'(pop);
      credit_ok    = (reserved_nxt <= (CNT_W+1)'(FIFO_DEPTH));
      issue        = (state_q == ISSUE) && (remaining_q != '0) && credit_ok;

      addr_d      = addr_q;
      remaining_d = remaining_q;
      ret_left_d  = ret_left_q;
      if (accept) begin
         addr_d      = req_addr;
         remaining_d = {1'b0, req_len} + REM_W'(1);
         ret_left_d  = {1'b0, req_len} + REM_W'(1);
      end else if (issue) begin
         addr_d      = addr_q + ADDR_WIDTH'(1);
         remaining_d = remaining_q - REM_W'(1);
      end
      if (push) begin
         ret_left_d = ret_left_q - REM_W'(1);
      end

      en_rd_d    = issue;
      addr_rd_d  = issue ? addr_q : addr_rd_q;
      inflight_d = inflight_q + CNT_W'(issue) - CNT_W'(push);
      count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
      wr_ptr_d   = wr_ptr_q + PTR_W'(push);
      rd_ptr_d   = rd_ptr_q + PTR_W'(pop);

      data_mem_d = data_mem_q;
      last_mem_d = last_mem_q;
      if (push) begin
         data_mem_d[wr_ptr_q] = dram_data;
         last_mem_d[wr_ptr_q] = (ret_left_q == REM_W'(1));
      end

      out_data = out_valid ? data_mem_q[rd_ptr_q] : '0;
      out_last = out_valid && last_mem_q[rd_ptr_q];
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept) state_d = ISSUE;
         ISSUE:   if (issue && (remaining_q == REM_W'(1))) state_d = DRAIN;
         DRAIN:   if (pop && out_last) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // The final pop leaves DRAIN and raises done together, so a new request can land while done is high
   always_comb begin
      req_ready    = (state_q == IDLE);
      busy         = (state_q != IDLE);
      done_d       = (state_q == DRAIN) && pop && out_last;
      done         = done_q;
      dram_en_rd   = en_rd_q;
      dram_addr_rd = addr_rd_q;
   end

   always_ff @(posedge clk or negedge srstn) begin
      if (!srstn) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         remaining_q <= '0;
         ret_left_q  <= '0;
         inflight_q  <= '0;
         count_q     <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         en_rd_q     <= 1'b0;
         addr_rd_q   <= '0;
         done_q      <= 1'b0;
         data_mem_q  <= '{default: '0};
         last_mem_q  <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         remaining_q <= remaining_d;
         ret_left_q  <= ret_left_d;
         inflight_q  <= inflight_d;
         count_q     <= count_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         en_rd_q     <= en_rd_d;
         addr_rd_q   <= addr_rd_d;
         done_q      <= done_d;
         data_mem_q  <= data_mem_d;
         last_mem_q  <= last_mem_d;
      end
   end
endmodule

// File: tb/tb_dram_burst_reader.sv
// Directed bench for dram_burst_reader with a one-cycle-latency DRAM model (data[a] = a).
module tb_dram_burst_reader;
   logic        clk = 1'b0;
   logic        srstn = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [17:0] req_addr = '0;
   logic [9:0]  req_len = '0;
   logic        dram_en_rd;
   logic [17:0] dram_addr_rd;
   logic        dram_valid = 1'b0;
   logic [31:0] dram_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic        out_last;
   logic        busy;
   logic        done;
   logic        inject_valid = 1'b0;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;

   logic [17:0] iss_addr[$];
   int          iss_cyc[$];
   logic [31:0] pop_data[$];
   logic        pop_last[$];
   int          pop_cyc[$];
   int          done_cyc[$];
   int          issue_cnt = 0, pop_cnt = 0, max_out = 0, stall_err = 0;
   logic        prev_stall = 1'b0;
   logic [31:0] prev_data = '0;
   logic        prev_last = 1'b0;

   dram_burst_reader #(.DATA_WIDTH(32), .ADDR_WIDTH(18), .LEN_WIDTH(10), .FIFO_DEPTH(4)) dut (
      .clk(clk), .srstn(srstn),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
      .dram_en_rd(dram_en_rd), .dram_addr_rd(dram_addr_rd),
      .dram_valid(dram_valid), .dram_data(dram_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // DRAM model is not reset, so reads issued before a reset can still return afterwards
   always @(posedge clk) begin
      dram_valid <= dram_en_rd | inject_valid;
      dram_data  <= dram_en_rd ? {14'd0, dram_addr_rd} : 32'hDEAD_BEEF;
   end

   always @(negedge clk) begin
      if (!srstn) begin
         issue_cnt  = 0;
         pop_cnt    = 0;
         prev_stall = 1'b0;
      end else begin
         if (dram_en_rd) begin
            iss_addr.push_back(dram_addr_rd);
            iss_cyc.push_back(cyc);
            issue_cnt++;
         end
         if (issue_cnt - pop_cnt > max_out) max_out = issue_cnt - pop_cnt;
         if (prev_stall && (!out_valid || out_data !== prev_data || out_last !== prev_last))
            stall_err++;
         if (out_valid && out_ready) begin
            pop_data.push_back(out_data);
            pop_last.push_back(out_last);
            pop_cyc.push_back(cyc);
            pop_cnt++;
         end
         if (done) done_cyc.push_back(cyc);
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         prev_last  = out_last;
      end
   end

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_logs();
      iss_addr.delete(); iss_cyc.delete();
      pop_data.delete(); pop_last.delete(); pop_cyc.delete();
      done_cyc.delete();
      max_out   = 0;
      stall_err = 0;
   endtask

   task automatic send_req(input logic [17:0] a, input logic [9:0] l, output int t);
      t = -1;
      req_addr  = a;
      req_len   = l;
      req_valid = 1'b1;
      for (int i = 0; i < 50 && t < 0; i++) begin
         if (req_ready) t = cyc + 1;
         step(1);
      end
      req_valid = 1'b0;
   endtask

   task automatic wait_done(input int n_done, input int budget);
      for (int i = 0; i < budget && done_cyc.size() < n_done; i++) step(1);
   endtask

   task automatic test_reset();
      #12;
      n_cmp++;
      if ({req_ready, busy, dram_en_rd, out_valid, out_last, done} !== 6'b100000) begin
         n_err++;
         $display("FAIL reset_flags: got %b required 100000", {req_ready, busy, dram_en_rd, out_valid, out_last, done});
      end
      n_cmp++;
      if (dram_addr_rd !== 18'h0 || out_data !== 32'h0) begin
         n_err++;
         $display("FAIL reset_values: addr_rd=%h out_data=%h required 0/0", dram_addr_rd, out_data);
      end
      step(2);
      srstn = 1'b1;
      step(2);
      n_cmp++;
      if ({req_ready, busy, dram_en_rd, out_valid, done} !== 5'b10000) begin
         n_err++;
         $display("FAIL idle_after_release: got %b required 10000", {req_ready, busy, dram_en_rd, out_valid, done});
      end
   endtask

   task automatic test_basic_burst();
      int t;
      clear_logs();
      out_ready = 1'b1;
      send_req(18'h00010, 10'd3, t);
      wait_done(1, 40);
      step(2);
      n_cmp++;
      if (t < 0 || done_cyc.size() !== 1) begin
         n_err++;
         $display("FAIL basic_done_count: accept=%0d dones=%0d required dones=1", t, done_cyc.size());
      end
      n_cmp++;
      if (iss_addr.size() !== 4) begin
         n_err++;
         $display("FAIL basic_issue_count: got %0d required 4", iss_addr.size());
      end
      for (int i = 0; i < 4 && i < iss_addr.size(); i++) begin
         n_cmp++;
         if (iss_addr[i] !== 18'(16 + i) || iss_cyc[i] !== t + 1 + i) begin
            n_err++;
            $display("FAIL basic_issue[%0d]: addr=%h cyc=%0d required addr=%h cyc=%0d", i, iss_addr[i], iss_cyc[i], 16 + i, t + 1 + i);
         end
      end
      n_cmp++;
      if (pop_data.size() !== 4) begin
         n_err++;
         $display("FAIL basic_word_count: got %0d required 4", pop_data.size());
      end
      for (int i = 0; i < 4 && i < pop_data.size(); i++) begin
         n_cmp++;
         if (pop_data[i] !== 32'(16 + i) || pop_last[i] !== (i == 3) || pop_cyc[i] !== t + 3 + i) begin
            n_err++;
            $display("FAIL basic_word[%0d]: data=%h last=%b cyc=%0d required data=%h last=%b cyc=%0d", i, pop_data[i], pop_last[i], pop_cyc[i], 16 + i, (i == 3), t + 3 + i);
         end
      end
      if (done_cyc.size() > 0) begin
         n_cmp++;
         if (done_cyc[0] !== t + 7) begin
            n_err++;
            $display("FAIL basic_done_cycle: got %0d required %0d", done_cyc[0], t + 7);
         end
      end
   endtask

   task automatic test_stall();
      int t;
      clear_logs();
      out_ready = 1'b0;
      send_req(18'h00100, 10'd9, t);
      step(20);
      n_cmp++;
      if (iss_addr.size() !== 4) begin
         n_err++;
         $display("FAIL stall_issue_count: got %0d required 4", iss_addr.size());
      end
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== 32'h100 || out_last !== 1'b0) begin
         n_err++;
         $display("FAIL stall_head: valid=%b data=%h last=%b required 1/00000100/0", out_valid, out_data, out_last);
      end
      out_ready = 1'b1;
      wait_done(1, 60);
      step(1);
      n_cmp++;
      if (pop_data.size() !== 10 || iss_addr.size() !== 10 || done_cyc.size() !== 1) begin
         n_err++;
         $display("FAIL stall_counts: words=%0d issues=%0d dones=%0d required 10/10/1", pop_data.size(), iss_addr.size(), done_cyc.size());
      end
      for (int i = 0; i < 10 && i < pop_data.size(); i++) begin
         n_cmp++;
         if (pop_data[i] !== 32'(256 + i) || pop_last[i] !== (i == 9)) begin
            n_err++;
            $display("FAIL stall_word[%0d]: data=%h last=%b required data=%h last=%b", i, pop_data[i], pop_last[i], 256 + i, (i == 9));
         end
      end
      n_cmp++;
      if (stall_err !== 0 || max_out > 4) begin
         n_err++;
         $display("FAIL stall_hold: changes=%0d max_reserved=%0d required 0 and <=4", stall_err, max_out);
      end
   endtask

   task automatic test_wrap();
      int t;
      logic [17:0] exp_addr[4];
      exp_addr = '{18'h3FFFE, 18'h3FFFF, 18'h00000, 18'h00001};
      clear_logs();
      out_ready = 1'b1;
      send_req(18'h3FFFE, 10'd3, t);
      wait_done(1, 40);
      step(1);
      n_cmp++;
      if (iss_addr.size() !== 4 || pop_data.size() !== 4) begin
         n_err++;
         $display("FAIL wrap_counts: issues=%0d words=%0d required 4/4", iss_addr.size(), pop_data.size());
      end
      for (int i = 0; i < 4 && i < iss_addr.size() && i < pop_data.size(); i++) begin
         n_cmp++;
         if (iss_addr[i] !== exp_addr[i] || pop_data[i] !== {14'd0, exp_addr[i]}) begin
            n_err++;
            $display("FAIL wrap_addr[%0d]: addr=%h data=%h required %h", i, iss_addr[i], pop_data[i], exp_addr[i]);
         end
      end
   endtask

   task automatic test_single_and_held_request();
      int t1, t2;
      clear_logs();
      out_ready = 1'b1;
      t1 = -1;
      t2 = -1;
      req_addr  = 18'h00055;
      req_len   = 10'd0;
      req_valid = 1'b1;
      for (int i = 0; i < 20 && t1 < 0; i++) begin
         if (req_ready) t1 = cyc + 1;
         step(1);
      end
      req_addr = 18'h00077;
      req_len  = 10'd1;
      for (int i = 0; i < 30 && t2 < 0; i++) begin
         if (req_ready) t2 = cyc + 1;
         step(1);
      end
      req_valid = 1'b0;
      wait_done(2, 40);
      step(1);
      n_cmp++;
      if (t1 < 0 || t2 !== t1 + 5) begin
         n_err++;
         $display("FAIL held_req_accept: second accept=%0d required %0d", t2, t1 + 5);
      end
      n_cmp++;
      if (done_cyc.size() !== 2 || pop_data.size() !== 3) begin
         n_err++;
         $display("FAIL single_counts: dones=%0d words=%0d required 2/3", done_cyc.size(), pop_data.size());
      end
      if (done_cyc.size() > 0) begin
         n_cmp++;
         if (done_cyc[0] !== t1 + 4) begin
            n_err++;
            $display("FAIL single_done_cycle: got %0d required %0d", done_cyc[0], t1 + 4);
         end
      end
      if (pop_data.size() == 3) begin
         n_cmp++;
         if (pop_data[0] !== 32'h55 || pop_last[0] !== 1'b1 || pop_data[1] !== 32'h77 || pop_last[1] !== 1'b0 || pop_data[2] !== 32'h78 || pop_last[2] !== 1'b1) begin
            n_err++;
            $display("FAIL single_words: got %h/%b %h/%b %h/%b required 55/1 77/0 78/1", pop_data[0], pop_last[0], pop_data[1], pop_last[1], pop_data[2], pop_last[2]);
         end
      end
   endtask

   task automatic test_random_ready();
      int t;
      int n_last;
      logic [15:0] lfsr;
      lfsr = 16'hACE1;
      n_last = 0;
      clear_logs();
      out_ready = 1'b0;
      send_req(18'h02000, 10'd49, t);
      for (int i = 0; i < 600 && done_cyc.size() < 1; i++) begin
         lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
         out_ready = lfsr[0];
         step(1);
      end
      out_ready = 1'b1;
      step(1);
      n_cmp++;
      if (pop_data.size() !== 50 || done_cyc.size() !== 1) begin
         n_err++;
         $display("FAIL random_counts: words=%0d dones=%0d required 50/1", pop_data.size(), done_cyc.size());
      end
      for (int i = 0; i < 50 && i < pop_data.size(); i++) begin
         if (pop_last[i]) n_last++;
         n_cmp++;
         if (pop_data[i] !== 32'(32'h2000 + i)) begin
            n_err++;
            $display("FAIL random_word[%0d]: got %h required %h", i, pop_data[i], 32'h2000 + i);
         end
      end
      n_cmp++;
      if (n_last !== 1 || pop_data.size() < 50 || pop_last[49] !== 1'b1) begin
         n_err++;
         $display("FAIL random_last: last_count=%0d required exactly one on word 49", n_last);
      end
      n_cmp++;
      if (stall_err !== 0 || max_out > 4) begin
         n_err++;
         $display("FAIL random_stall: changes=%0d max_reserved=%0d required 0 and <=4", stall_err, max_out);
      end
   endtask

   task automatic test_reset_mid_burst();
      int t;
      clear_logs();
      out_ready = 1'b1;
      send_req(18'h00300, 10'd9, t);
      for (int i = 0; i < 30 && pop_data.size() < 3; i++) step(1);
      #2;
      srstn = 1'b0;
      #1;
      n_cmp++;
      if ({req_ready, busy, dram_en_rd, out_valid, out_last, done} !== 6'b100000 || dram_addr_rd !== 18'h0 || out_data !== 32'h0) begin
         n_err++;
         $display("FAIL async_reset: flags=%b addr_rd=%h data=%h required 100000/0/0", {req_ready, busy, dram_en_rd, out_valid, out_last, done}, dram_addr_rd, out_data);
      end
      step(2);
      srstn = 1'b1;
      step(6);
      n_cmp++;
      if (done_cyc.size() !== 0 || pop_data.size() !== 3 || out_valid !== 1'b0 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL reset_abort: dones=%0d words=%0d valid=%b busy=%b required 0/3/0/0", done_cyc.size(), pop_data.size(), out_valid, busy);
      end
      clear_logs();
      send_req(18'h00040, 10'd2, t);
      wait_done(1, 40);
      step(1);
      n_cmp++;
      if (pop_data.size() !== 3 || done_cyc.size() !== 1) begin
         n_err++;
         $display("FAIL post_reset_counts: words=%0d dones=%0d required 3/1", pop_data.size(), done_cyc.size());
      end
      for (int i = 0; i < 3 && i < pop_data.size(); i++) begin
         n_cmp++;
         if (pop_data[i] !== 32'(64 + i) || pop_last[i] !== (i == 2)) begin
            n_err++;
            $display("FAIL post_reset_word[%0d]: data=%h last=%b required %h/%b", i, pop_data[i], pop_last[i], 64 + i, (i == 2));
         end
      end
   endtask

   task automatic test_stray_valid();
      int t;
      clear_logs();
      out_ready = 1'b1;
      inject_valid = 1'b1;
      step(1);
      inject_valid = 1'b0;
      step(3);
      n_cmp++;
      if (pop_data.size() !== 0 || out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL stray_valid: words=%0d valid=%b required 0/0", pop_data.size(), out_valid);
      end
      send_req(18'h00500, 10'd1, t);
      wait_done(1, 40);
      step(1);
      n_cmp++;
      if (pop_data.size() !== 2 || pop_data[0] !== 32'h500 || pop_last[0] !== 1'b0 || pop_data[1] !== 32'h501 || pop_last[1] !== 1'b1) begin
         n_err++;
         $display("FAIL stray_followup: words=%0d required 500/0 501/1", pop_data.size());
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset();
      test_basic_burst();
      test_stall();
      test_wrap();
      test_single_and_held_request();
      test_random_ready();
      test_reset_mid_burst();
      test_stray_valid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/dram_burst_reader.md
# dram_burst_reader

Read-side initiator for the on-chip DRAM model's read port (en_rd/addr_rd in, valid/data_out back one cycle later). It accepts a burst request (start address, word count), issues one DRAM read per cycle, and buffers returned words in a small FIFO. Data leaves on a valid/ready stream with a last flag. It sits between the weight/pattern loaders and the DRAM and throttles issue so the FIFO can never overflow.

## Interface
- DATA_WIDTH, 32, DRAM word width
- ADDR_WIDTH, 18, DRAM address width
- LEN_WIDTH, 10, burst length field width; a burst carries req_len+1 words
- FIFO_DEPTH, 4, output buffer entries (power of 2, ≥2)
- clk  input  1  single clock, rising edge
- srstn  input  1  reset; asynchronous, active-low
- req_valid  input  1  burst request valid
- req_ready  output  1  block idle, can accept a request
- req_addr  input  ADDR_WIDTH  first word address
- req_len  input  LEN_WIDTH  word count minus one
- dram_en_rd  output  1  DRAM read enable (registered)
- dram_addr_rd  output  ADDR_WIDTH  DRAM read address (registered)
- dram_valid  input  1  DRAM read data valid, one cycle after dram_en_rd
- dram_data  input  DATA_WIDTH  DRAM read data
- out_valid  output  1  out_data holds a word
- out_ready  input  1  consumer accepts word
- out_data  output  DATA_WIDTH  burst word
- out_last  output  1  marks final word of burst
- busy  output  1  burst in progress (state ≠ IDLE)
- done  output  1  one-cycle pulse after final word is popped

## Operation
- States: IDLE, ISSUE, DRAIN.
- IDLE: req_ready=1. On req_valid & req_ready: latch addr, load remaining = req_len+1 (LEN_WIDTH+1 bits), go to ISSUE.
- ISSUE: drive dram_en_rd=1 with current address whenever credit allows; each issue increments address and decrements remaining. When the final word is issued, go to DRAIN.
- DRAIN: wait until the FIFO is empty and no reads are in flight, with the last word popped. Then pulse done for one cycle and return to IDLE.
- Credit: reserved = FIFO occupancy + reads issued whose data has not yet been written. An issue is allowed only if reserved stays ≤ FIFO_DEPTH, counting a same-cycle pop as freeing one entry. FIFO overflow is therefore impossible by construction.
- Each dram_valid writes dram_data into the FIFO along with a last tag. The tag is set on the (req_len+1)-th returned word.
- dram_valid while no read is in flight is ignored: no push, no counter change.
- Address increment wraps modulo 2**ADDR_WIDTH (all-ones → 0).
- req_valid while busy is ignored; req_ready=0 outside IDLE.
- out_data and out_last are held stable while out_valid & !out_ready.
- Simultaneous push and pop is legal at any occupancy, including full and empty-plus-bypass-free (no combinational bypass: a word is poppable the cycle after its push).

## Timing
- Reset values: state=IDLE, req_ready=1, dram_en_rd=0, dram_addr_rd=0, out_valid=0, out_last=0, out_data=0, busy=0, done=0. FIFO emptied, counters cleared.
- Reset mid-burst aborts immediately with no done pulse. Data returning after reset release is ignored, because there is no in-flight read.
- Handshake accepted at edge T gives: dram_en_rd=1 with addr=req_addr in cycle T+1; dram_valid in T+2; out_valid in T+3.
- With out_ready held 1: one word per cycle, words at T+3 … T+3+req_len, out_last on the final one, and done in the cycle after the last pop.
- Earliest next request accept: the cycle done is high (state already IDLE).
- With out_ready held 0: at most FIFO_DEPTH reads are issued, then dram_en_rd stays 0 until a pop.

## Test plan
- Reset, then req_addr=0x00010, req_len=3, out_ready=1, DRAM preloaded data[a]=a → dram_en_rd asserted 4 consecutive cycles, addr 0x10..0x13; out_data 0x10..0x13 back-to-back from T+3; out_last on 0x13; done one cycle later.
- req_len=9, out_ready=0 for 20 cycles then 1 → exactly FIFO_DEPTH=4 reads issued while stalled; out_data 0 held; afterwards all 10 words in order, no loss or duplication.
- req_addr=0x3FFFE, req_len=3 → addresses 0x3FFFE, 0x3FFFF, 0x00000, 0x00001.
- req_len=0 → single read, single word with out_last=1, done pulse; second req_valid held during the burst is accepted only when req_ready returns to 1.
- out_ready toggled randomly on a 50-word burst → order preserved, out_data stable under stall, reserved never exceeds 4.
- srstn asserted mid-burst after 3 words → all outputs return to reset values asynchronously; no done; a new burst after release completes correctly.
